// File: rtl/qbert_pkg.sv
// Shared types and constants for the Q*bert pyramid colour logic.
// Pure declarations: no latency, no flow control.
package qbert_pkg;

    localparam int N_CUBE = 28;
    localparam logic [N_CUBE-1:0] ALL_CUBES = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        WON   = 2'd3
    } sched_state_t;

    typedef enum logic {
        SET    = 1'b0,
        TOGGLE = 1'b1
    } color_mode_t;

    // Only encoding 1 toggles; the spare encodings fall back to SET.
    function automatic color_mode_t decode_mode(input logic [1:0] cfg);
        return (cfg == 2'd1) ? TOGGLE : SET;
    endfunction

endpackage

// File: rtl/onehot_check.sv
// Flags a cube vector that selects exactly one cube (zero is rejected).
// Latency: combinational. Backpressure: none.
module onehot_check
    import qbert_pkg::*;
#(
    parameter int N = N_CUBE
) (
    input  logic [N-1:0] vec,
    output logic         valid
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    always_comb begin
        valid = (vec != '0) && ((vec & (vec - ONE)) == '0);
    end

endmodule

// File: rtl/cube_color_scheduler.sv
// Owns the pyramid colour vector: serialises Q*bert landings and enemy reverts, scores cubes, detects level completion.
// Latency: landing -> colour/score 2 cycles, -> level_done 3 cycles; en_req -> en_ack/colour 2 cycles.
// Backpressure: one-deep landing slot (overwrite raises overrun); en_req held until en_ack, never acked in WON.
module cube_color_scheduler
    import qbert_pkg::*;
#(
    parameter int N_CUBE = 28
) (
    input  logic              CLK_33,
    input  logic              reset,
    input  logic              level_start,
    input  logic [1:0]        cfg_mode,
    input  logic              land_req,
    input  logic [N_CUBE-1:0] position_qb,
    input  logic              en_req,
    input  logic [N_CUBE-1:0] en_pos,
    input  logic              e_freeze_power,
    output logic              en_ack,
    output logic [N_CUBE-1:0] color_state,
    output logic              cube_scored,
    output logic              level_done,
    output logic              won,
    output logic              overrun
);

    sched_state_t      state;
    color_mode_t       mode;
    logic              pend_vld;
    logic [N_CUBE-1:0] pend_pos;
    logic              sel_en;
    logic              en_req_q;
    logic              en_armed;
    logic              pend_ok;
    logic              en_ok;
    logic              qb_take;
    logic              en_take;

    onehot_check #(.N(N_CUBE)) u_qb_chk (
        .vec   (pend_pos),
        .valid (pend_ok)
    );

    onehot_check #(.N(N_CUBE)) u_en_chk (
        .vec   (en_pos),
        .valid (en_ok)
    );

    assign qb_take = (state == APPLY) && !sel_en;
    assign en_take = (state == APPLY) &&  sel_en;

    // The requester keeps en_req high for a cycle after seeing en_ack, so a
    // served request is disarmed until the registered copy has been seen low.
    always_ff @(posedge CLK_33 or negedge reset) begin
        if (!reset) begin
            en_req_q <= 1'b0;
            en_armed <= 1'b1;
        end else begin
            en_req_q <= en_req;
            if (en_take && !level_start) begin
                en_armed <= 1'b0;
            end else if (!en_req_q) begin
                en_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_33 or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            mode        <= SET;
            pend_vld    <= 1'b0;
            pend_pos    <= '0;
            sel_en      <= 1'b0;
            color_state <= '0;
            en_ack      <= 1'b0;
            cube_scored <= 1'b0;
            level_done  <= 1'b0;
            won         <= 1'b0;
            overrun     <= 1'b0;
        end else if (level_start) begin
            state       <= IDLE;
            mode        <= decode_mode(cfg_mode);
            pend_vld    <= 1'b0;
            pend_pos    <= '0;
            sel_en      <= 1'b0;
            color_state <= '0;
            en_ack      <= 1'b0;
            cube_scored <= 1'b0;
            level_done  <= 1'b0;
            won         <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            en_ack      <= 1'b0;
            cube_scored <= 1'b0;
            level_done  <= 1'b0;

            // A new landing always wins the slot, even on the cycle it is consumed.
            if (land_req) begin
                pend_vld <= 1'b1;
                pend_pos <= position_qb;
                if (pend_vld && !qb_take) begin
                    overrun <= 1'b1;
                end
            end else if (qb_take) begin
                pend_vld <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pend_vld) begin
                        sel_en <= 1'b0;
                        state  <= APPLY;
                    end else if (en_req_q && en_armed) begin
                        sel_en <= 1'b1;
                        state  <= APPLY;
                    end
                end
                APPLY: begin
                    if (!sel_en) begin
                        if (pend_ok) begin
                            color_state <= (mode == TOGGLE) ? (color_state ^ pend_pos)
                                                            : (color_state | pend_pos);
                            cube_scored <= ((color_state & pend_pos) == '0);
                        end
                        state <= CHECK;
                    end else begin
                        en_ack <= 1'b1;
                        if (!e_freeze_power && en_ok) begin
                            color_state <= color_state & ~en_pos;
                        end
                        state <= IDLE;
                    end
                end
                CHECK: begin
                    if (&color_state) begin
                        level_done <= 1'b1;
                        won        <= 1'b1;
                        state      <= WON;
                    end else begin
                        state <= IDLE;
                    end
                end
                WON: begin
                    state <= WON;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cube_color_scheduler.sv
// Scoreboard bench: stimulus queues expectations from a cube-array model, a negedge monitor pops and compares.
module tb_cube_color_scheduler;

    localparam int NC = 28;

    logic          CLK_33;
    logic          reset;
    logic          level_start;
    logic [1:0]    cfg_mode;
    logic          land_req;
    logic [NC-1:0] position_qb;
    logic          en_req;
    logic [NC-1:0] en_pos;
    logic          e_freeze_power;
    logic          en_ack;
    logic [NC-1:0] color_state;
    logic          cube_scored;
    logic          level_done;
    logic          won;
    logic          overrun;

    cube_color_scheduler #(.N_CUBE(NC)) dut (
        .CLK_33         (CLK_33),
        .reset          (reset),
        .level_start    (level_start),
        .cfg_mode       (cfg_mode),
        .land_req       (land_req),
        .position_qb    (position_qb),
        .en_req         (en_req),
        .en_pos         (en_pos),
        .e_freeze_power (e_freeze_power),
        .en_ack         (en_ack),
        .color_state    (color_state),
        .cube_scored    (cube_scored),
        .level_done     (level_done),
        .won            (won),
        .overrun        (overrun)
    );

    initial CLK_33 = 1'b0;
    always #15 CLK_33 = ~CLK_33;

    typedef struct {
        logic [NC-1:0] color;
        bit            scored;
        bit            done;
    } land_exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    land_exp_t     qb_q[$];
    bit            done_q[$];
    logic [NC-1:0] en_q[$];
    chk_t          chk_q[$];
    int            total = 0;
    int            bad = 0;

    // Reference model: one bit per cube plus the level rule and won flag.
    bit m_color[NC];
    bit m_toggle;
    bit m_won;

    logic [3:0] land_hist;

    function automatic logic [NC-1:0] oh(input int i);
        logic [NC-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [NC-1:0] m_pack();
        logic [NC-1:0] v;
        for (int i = 0; i < NC; i++) v[i] = m_color[i];
        return v;
    endfunction

    function automatic int cube_of(input logic [NC-1:0] p);
        int n = 0;
        int idx = -1;
        for (int i = 0; i < NC; i++) begin
            if (p[i]) begin
                n++;
                idx = i;
            end
        end
        return (n == 1) ? idx : -1;
    endfunction

    function automatic void m_reset(input bit toggle);
        for (int i = 0; i < NC; i++) m_color[i] = 1'b0;
        m_toggle = toggle;
        m_won = 1'b0;
    endfunction

    function automatic land_exp_t m_land(input logic [NC-1:0] p);
        land_exp_t e;
        int i;
        int lit;
        i = cube_of(p);
        e.scored = 1'b0;
        e.done = 1'b0;
        if (!m_won && i >= 0) begin
            e.scored = !m_color[i];
            m_color[i] = m_toggle ? !m_color[i] : 1'b1;
            lit = 0;
            for (int k = 0; k < NC; k++) lit += int'(m_color[k]);
            if (lit == NC) begin
                e.done = 1'b1;
                m_won = 1'b1;
            end
        end
        e.color = m_pack();
        return e;
    endfunction

    function automatic logic [NC-1:0] m_enemy(input logic [NC-1:0] p, input bit frz);
        int i;
        i = cube_of(p);
        if (i >= 0 && !frz) m_color[i] = 1'b0;
        return m_pack();
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
        chk_t c;
        c.name = nm;
        c.act = a;
        c.exp = x;
        chk_q.push_back(c);
    endtask

    always @(posedge CLK_33 or negedge reset) begin
        if (!reset) land_hist <= 4'b0;
        else        land_hist <= {land_hist[2:0], land_req};
    end

    always @(negedge CLK_33) begin : monitor
        land_exp_t     e;
        chk_t          c;
        bit            d;
        logic [NC-1:0] ec;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            total++;
            if (c.act !== c.exp) begin
                bad++;
                $display("FAIL %s: got %0h want %0h", c.name, c.act, c.exp);
            end
        end
        if (reset === 1'b1) begin
            if (land_hist[2] === 1'b1) begin
                if (qb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL land_unexpected: got a landing check with no expectation at %0t, want queued entry", $time);
                end else begin
                    e = qb_q.pop_front();
                    done_q.push_back(e.done);
                    total++;
                    if (color_state !== e.color) begin
                        bad++;
                        $display("FAIL land_color: got %h want %h", color_state, e.color);
                    end
                    total++;
                    if (cube_scored !== e.scored) begin
                        bad++;
                        $display("FAIL land_score: got %b want %b", cube_scored, e.scored);
                    end
                end
            end else if (cube_scored !== 1'b0) begin
                total++; bad++;
                $display("FAIL stray_score: got %b want 0 at %0t", cube_scored, $time);
            end
            if (land_hist[3] === 1'b1) begin
                if (done_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done_unexpected: got a done check with no expectation, want queued entry");
                end else begin
                    d = done_q.pop_front();
                    total++;
                    if (level_done !== d) begin
                        bad++;
                        $display("FAIL land_done: got %b want %b", level_done, d);
                    end
                end
            end else if (level_done !== 1'b0) begin
                total++; bad++;
                $display("FAIL stray_done: got %b want 0 at %0t", level_done, $time);
            end
            if (en_ack === 1'b1) begin
                if (en_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ack_unexpected: got en_ack=1 want 0 at %0t", $time);
                end else begin
                    ec = en_q.pop_front();
                    total++;
                    if (color_state !== ec) begin
                        bad++;
                        $display("FAIL enemy_color: got %h want %h", color_state, ec);
                    end
                end
            end
        end
    end

    task automatic do_level_start(input logic [1:0] m);
        @(negedge CLK_33);
        level_start = 1'b1;
        cfg_mode = m;
        m_reset(m == 2'd1);
        @(negedge CLK_33);
        level_start = 1'b0;
    endtask

    task automatic land(input logic [NC-1:0] pos);
        @(negedge CLK_33);
        land_req = 1'b1;
        position_qb = pos;
        qb_q.push_back(m_land(pos));
        @(negedge CLK_33);
        land_req = 1'b0;
        repeat (4) @(negedge CLK_33);
    endtask

    task automatic wait_ack();
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge CLK_33);
            if (en_ack === 1'b1) seen = 1'b1;
        end
        if (!seen) chk("en_ack_timeout", 32'd0, 32'd1);
        @(negedge CLK_33);
        en_req = 1'b0;
        repeat (3) @(negedge CLK_33);
    endtask

    task automatic enemy(input logic [NC-1:0] pos, input bit frz);
        @(negedge CLK_33);
        en_req = 1'b1;
        en_pos = pos;
        e_freeze_power = frz;
        en_q.push_back(m_enemy(pos, frz));
        wait_ack();
    endtask

    // Two landings on consecutive cycles: only the later position may be written.
    task automatic do_overrun(input int a, input int b);
        land_exp_t ea;
        land_exp_t eb;
        @(negedge CLK_33);
        land_req = 1'b1;
        position_qb = oh(a);
        @(negedge CLK_33);
        position_qb = oh(b);
        ea = m_land(oh(b));
        eb.color = ea.color;
        eb.scored = 1'b0;
        eb.done = 1'b0;
        qb_q.push_back(ea);
        qb_q.push_back(eb);
        @(negedge CLK_33);
        land_req = 1'b0;
        repeat (5) @(negedge CLK_33);
        chk("overrun_set", 32'(overrun), 32'd1);
    endtask

    initial begin : stim
        bit            saw;
        int            r;
        logic [NC-1:0] p;
        reset = 1'b0;
        level_start = 1'b0;
        cfg_mode = 2'd0;
        land_req = 1'b0;
        position_qb = '0;
        en_req = 1'b0;
        en_pos = '0;
        e_freeze_power = 1'b0;
        m_reset(1'b0);
        repeat (3) @(negedge CLK_33);
        chk("rst_color", 32'(color_state), 32'd0);
        chk("rst_en_ack", 32'(en_ack), 32'd0);
        chk("rst_scored", 32'(cube_scored), 32'd0);
        chk("rst_done", 32'(level_done), 32'd0);
        chk("rst_won", 32'(won), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        @(negedge CLK_33);
        reset = 1'b1;

        do_level_start(2'd0);
        land(oh(0));
        land(oh(0));
        land(28'h0000003);
        land(28'h0000000);

        do_level_start(2'd1);
        land(oh(5));
        land(oh(5));

        // Landing and revert of the same cube in one cycle: landing first.
        do_level_start(2'd0);
        @(negedge CLK_33);
        land_req = 1'b1;
        position_qb = oh(3);
        en_req = 1'b1;
        en_pos = oh(3);
        e_freeze_power = 1'b0;
        qb_q.push_back(m_land(oh(3)));
        en_q.push_back(m_enemy(oh(3), 1'b0));
        @(negedge CLK_33);
        land_req = 1'b0;
        wait_ack();

        land(oh(7));
        enemy(oh(7), 1'b1);
        enemy(oh(7), 1'b0);

        do_level_start(2'd2);
        for (int i = 0; i < NC - 1; i++) land(oh(i));
        land(oh(NC - 1));
        chk("won_set", 32'(won), 32'd1);
        @(negedge CLK_33);
        en_req = 1'b1;
        en_pos = oh(0);
        e_freeze_power = 1'b0;
        saw = 1'b0;
        repeat (8) begin
            @(negedge CLK_33);
            if (en_ack === 1'b1) saw = 1'b1;
        end
        chk("won_no_ack", 32'(saw), 32'd0);
        land(oh(0));
        do_level_start(2'd0);
        en_q.push_back(m_enemy(oh(0), 1'b0));
        chk("ls_color", 32'(color_state), 32'd0);
        chk("ls_won", 32'(won), 32'd0);
        wait_ack();

        do_level_start(2'd0);
        do_overrun(10, 11);
        do_level_start(2'd0);
        chk("ls_overrun", 32'(overrun), 32'd0);
        do_overrun(14, 15);

        // Asynchronous reset while the FSM sits in APPLY.
        @(negedge CLK_33);
        land_req = 1'b1;
        position_qb = oh(12);
        @(posedge CLK_33);
        #1 land_req = 1'b0;
        @(posedge CLK_33);
        #2 reset = 1'b0;
        #1;
        chk("arst_color", 32'(color_state), 32'd0);
        chk("arst_en_ack", 32'(en_ack), 32'd0);
        chk("arst_scored", 32'(cube_scored), 32'd0);
        chk("arst_done", 32'(level_done), 32'd0);
        chk("arst_won", 32'(won), 32'd0);
        chk("arst_overrun", 32'(overrun), 32'd0);
        repeat (2) @(negedge CLK_33);
        qb_q.delete();
        done_q.delete();
        en_q.delete();
        m_reset(1'b0);
        reset = 1'b1;
        land(oh(4));
        land(oh(4));

        do_level_start(2'($urandom_range(0, 3)));
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 99);
            if (r < 5 || (m_won && r >= 60)) begin
                do_level_start(2'($urandom_range(0, 3)));
            end else if (r < 60) begin
                p = ($urandom_range(0, 9) == 0) ? NC'($urandom()) : oh($urandom_range(0, NC - 1));
                land(p);
            end else begin
                p = ($urandom_range(0, 9) == 0) ? NC'($urandom()) : oh($urandom_range(0, NC - 1));
                enemy(p, $urandom_range(0, 3) == 0);
            end
        end

        repeat (6) @(negedge CLK_33);
        chk("qb_queue_empty", 32'(qb_q.size()), 32'd0);
        chk("en_queue_empty", 32'(en_q.size()), 32'd0);
        repeat (2) @(negedge CLK_33);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: got no finish within time limit, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
